// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller: operands are shifted LSB-first through one
// gate-level full adder, with carry-out and signed overflow returned through valid/ready.

module FULL_ADDER (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic S,
    output logic Cout
);
    logic ab_x_s;
    logic ab_a_s;
    logic cx_a_s;

    xor g_x0 (ab_x_s, A, B);
    xor g_x1 (S, ab_x_s, Cin);
    and g_a0 (ab_a_s, A, B);
    and g_a1 (cx_a_s, ab_x_s, Cin);
    or  g_o0 (Cout, ab_a_s, cx_a_s);
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             busy
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cmsb_q, cmsb_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fa_s;
    logic             fa_cout;

    FULL_ADDER u_fa (
        .A    (a_q[0]),
        .B    (b_q[0]),
        .Cin  (carry_q),
        .S    (fa_s),
        .Cout (fa_cout)
    );

    // Next-state and datapath updates for the IDLE/RUN/DONE sequence
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cmsb_d  = cmsb_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    // Subtraction is A + ~B + 1, the +1 entering as the initial carry
                    a_d     = in_a;
                    b_d     = in_sub ? ~in_b : in_b;
                    carry_d = in_sub;
                    cnt_d   = {CNT_W{1'b0}};
                    sum_d   = {WIDTH{1'b0}};
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                sum_d   = {fa_s, sum_q[WIDTH-1:1]};
                carry_d = fa_cout;
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                if (cnt_q == CNT_W'(WIDTH - 2)) begin
                    cmsb_d = fa_cout;
                end else begin
                    cmsb_d = cmsb_q;
                end
                // Counter parks on the MSB index instead of wrapping
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    ovf_d   = fa_cout ^ cmsb_q;
                    cnt_d   = cnt_q;
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            sum_q   <= {WIDTH{1'b0}};
            carry_q <= 1'b0;
            cmsb_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cmsb_q  <= cmsb_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_RUN);
    assign out_valid = (state_q == ST_DONE);
    assign out_sum   = sum_q;
    assign out_cout  = carry_q;
    assign out_ovf   = ovf_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and random scoreboard bench for serial_add_ctrl at WIDTH = 8.

module tb_serial_add_ctrl;
    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         v;
    } exp_t;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         in_sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;
    logic         busy;

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   last_acc = 0;
    bit   have_last = 1'b0;
    exp_t sbq[$];

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        exp_t r;
        r.s = sub ? (a - b) : (a + b);
        if (sub) begin
            r.c = (a >= b);
            r.v = (a[W-1] != b[W-1]) && (r.s[W-1] != a[W-1]);
        end else begin
            r.c = ({1'b0, a} + {1'b0, b}) > {1'b0, {W{1'b1}}};
            r.v = (a[W-1] == b[W-1]) && (r.s[W-1] != a[W-1]);
        end
        return r;
    endfunction

    // Present one request, check the accept, spacing, busy length and latency
    task automatic accept_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub, input exp_t e);
        int n;
        int busy_n;
        sbq.push_back(e);
        @(negedge clk);
        in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1;
        check("in_ready_idle", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (have_last) check("accept_spacing", (cyc - last_acc) >= (W + 2), 1);
        last_acc = cyc;
        have_last = 1'b1;
        busy_n = busy ? 1 : 0;
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (busy) busy_n++;
        end
        check("latency", n, W);
        check("busy_cycles", busy_n, W);
    endtask

    // Optionally stall in DONE (with input noise), then consume and compare the result
    task automatic finish_op(input int stall, input bit noise);
        exp_t e;
        e = sbq[0];
        for (int i = 0; i < stall; i++) begin
            check("stall_valid", out_valid, 1);
            check("stall_in_ready", in_ready, 0);
            check("stall_sum", out_sum, e.s);
            check("stall_cout", out_cout, e.c);
            check("stall_ovf", out_ovf, e.v);
            if (noise) begin
                in_valid = 1'($urandom_range(1, 0));
                in_a = W'($urandom);
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        e = sbq.pop_front();
        check("out_valid", out_valid, 1);
        check("sum", out_sum, e.s);
        check("cout", out_cout, e.c);
        check("ovf", out_ovf, e.v);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("idle_in_ready", in_ready, 1);
        check("idle_out_valid", out_valid, 0);
        check("hold_sum", out_sum, e.s);
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rs;
        bit           seen;

        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_sum", out_sum, 0);
        check("rst_cout_ovf", {out_cout, out_ovf}, 0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;

        accept_op(8'h3C, 8'h5A, 1'b0, '{s: 8'h96, c: 1'b0, v: 1'b1});
        finish_op(0, 1'b0);
        accept_op(8'hFF, 8'h01, 1'b0, '{s: 8'h00, c: 1'b1, v: 1'b0});
        finish_op(0, 1'b0);
        accept_op(8'h7F, 8'h01, 1'b0, '{s: 8'h80, c: 1'b0, v: 1'b1});
        finish_op(0, 1'b0);
        accept_op(8'h05, 8'h07, 1'b1, '{s: 8'hFE, c: 1'b0, v: 1'b0});
        finish_op(0, 1'b0);
        accept_op(8'h80, 8'h01, 1'b1, '{s: 8'h7F, c: 1'b1, v: 1'b1});
        finish_op(5, 1'b1);

        // Reset three cycles into RUN of 0xFF + 0xFF
        @(negedge clk);
        in_a = 8'hFF; in_b = 8'hFF; in_sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_valid", out_valid, 0);
        check("abort_sum", out_sum, 0);
        check("abort_cout_ovf", {out_cout, out_ovf}, 0);
        check("abort_in_ready", in_ready, 1);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        have_last = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            seen = seen | out_valid;
        end
        check("no_valid_after_abort", seen, 0);
        accept_op(8'h10, 8'h01, 1'b0, '{s: 8'h11, c: 1'b0, v: 1'b0});
        finish_op(0, 1'b0);

        for (int k = 0; k < 200; k++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rs = 1'($urandom_range(1, 0));
            accept_op(ra, rb, rs, model(ra, rb, rs));
            finish_op(int'($urandom_range(3, 0)), 1'b0);
        end

        check("scoreboard_empty", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
